// File: rtl/scalar_lane_xchg_if.sv
// Scalar-unit <-> lane exchange bus: broadcast write port plus gather stream.
// The master side is the scalar pipeline and lanes; the slave side is the exchange endpoint.
interface scalar_lane_xchg_if #(
    parameter int NUM_LANES  = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LANE_W     = $clog2(NUM_LANES)
);
    logic                            I_Stall;
    logic                            I_Bcast_Req;
    logic [DATA_WIDTH-1:0]           I_Bcast_Data;
    logic [NUM_LANES-1:0]            I_Bcast_Mask;
    logic                            O_Bcast_Ack;
    logic [NUM_LANES-1:0]            O_SWe;
    logic [DATA_WIDTH-1:0]           O_Scalar_Data;
    logic                            I_Gather_Req;
    logic [NUM_LANES-1:0]            I_Gather_Mask;
    logic [NUM_LANES*DATA_WIDTH-1:0] I_Lane_Data;
    logic                            O_Gather_Valid;
    logic [DATA_WIDTH-1:0]           O_Gather_Data;
    logic [LANE_W-1:0]               O_Gather_Lane;
    logic                            O_Gather_Last;
    logic                            I_Gather_Ready;
    logic                            O_Gather_Done;
    logic                            O_Busy;

    modport master (
        output I_Stall, I_Bcast_Req, I_Bcast_Data, I_Bcast_Mask,
        output I_Gather_Req, I_Gather_Mask, I_Lane_Data, I_Gather_Ready,
        input  O_Bcast_Ack, O_SWe, O_Scalar_Data,
        input  O_Gather_Valid, O_Gather_Data, O_Gather_Lane, O_Gather_Last,
        input  O_Gather_Done, O_Busy
    );

    modport slave (
        input  I_Stall, I_Bcast_Req, I_Bcast_Data, I_Bcast_Mask,
        input  I_Gather_Req, I_Gather_Mask, I_Lane_Data, I_Gather_Ready,
        output O_Bcast_Ack, O_SWe, O_Scalar_Data,
        output O_Gather_Valid, O_Gather_Data, O_Gather_Lane, O_Gather_Last,
        output O_Gather_Done, O_Busy
    );
endinterface

// File: rtl/scalar_lane_xchg.sv
// Scalar-side endpoint of the lane exchange: broadcasts one word into masked lane
// scalar registers, and gathers masked lane words in ascending order over a valid/ready stream.
module scalar_lane_xchg #(
    parameter int NUM_LANES  = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LANE_W     = $clog2(NUM_LANES)
) (
    input logic               clock,
    input logic               reset,
    scalar_lane_xchg_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BCAST, GATHER} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
    logic [NUM_LANES-1:0]  smask_q, smask_d;
    logic [DATA_WIDTH-1:0] gdata_q, gdata_d;
    logic [LANE_W-1:0]     glane_q, glane_d;
    logic                  gvld_q, gvld_d;
    logic [NUM_LANES-1:0]  pend_q, pend_d;
    logic                  done_q, done_d;

    logic [NUM_LANES-1:0]  load_mask;
    logic [NUM_LANES-1:0]  load_rest;
    logic [LANE_W-1:0]     load_lane;
    logic [DATA_WIDTH-1:0] load_word;

    // The first word comes from the request mask, later ones from the pending set.
    always_comb begin
        load_mask = (state_q == IDLE) ? bus.I_Gather_Mask : pend_q;
        load_rest = load_mask & (load_mask - NUM_LANES'(1));
        load_lane = '0;
        load_word = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (load_mask[i]) begin
                load_lane = LANE_W'(i);
                load_word = bus.I_Lane_Data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sdata_d = sdata_q;
        smask_d = smask_q;
        gdata_d = gdata_q;
        glane_d = glane_q;
        gvld_d  = gvld_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.I_Bcast_Req) begin
                    sdata_d = bus.I_Bcast_Data;
                    smask_d = bus.I_Bcast_Mask;
                    state_d = BCAST;
                end else if (bus.I_Gather_Req) begin
                    if (bus.I_Gather_Mask == '0) begin
                        done_d = 1'b1;
                    end else begin
                        gdata_d = load_word;
                        glane_d = load_lane;
                        gvld_d  = 1'b1;
                        pend_d  = load_rest;
                        state_d = GATHER;
                    end
                end
            end
            BCAST: state_d = IDLE;
            GATHER: begin
                if (gvld_q && bus.I_Gather_Ready) begin
                    if (pend_q != '0) begin
                        gdata_d = load_word;
                        glane_d = load_lane;
                        pend_d  = load_rest;
                    end else begin
                        gvld_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stall freezes every register; the lane write strobe is gated separately below.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sdata_q <= '0;
            smask_q <= '0;
            gdata_q <= '0;
            glane_q <= '0;
            gvld_q  <= 1'b0;
            pend_q  <= '0;
            done_q  <= 1'b0;
        end else if (!bus.I_Stall) begin
            state_q <= state_d;
            sdata_q <= sdata_d;
            smask_q <= smask_d;
            gdata_q <= gdata_d;
            glane_q <= glane_d;
            gvld_q  <= gvld_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

    assign bus.O_Bcast_Ack    = (state_q == BCAST) && !bus.I_Stall;
    assign bus.O_SWe          = bus.O_Bcast_Ack ? smask_q : '0;
    assign bus.O_Scalar_Data  = sdata_q;
    assign bus.O_Gather_Valid = gvld_q;
    assign bus.O_Gather_Data  = gdata_q;
    assign bus.O_Gather_Lane  = glane_q;
    assign bus.O_Gather_Last  = gvld_q && (pend_q == '0);
    assign bus.O_Gather_Done  = done_q;
    assign bus.O_Busy         = (state_q != IDLE);
endmodule

// File: tb/tb_scalar_lane_xchg.sv
// Bench for scalar_lane_xchg: directed broadcast/gather scenarios plus randomized gathers
// checked by a queue-based scoreboard and an independent monitor process.
module tb_scalar_lane_xchg;
    localparam int NL = 16;
    localparam int DW = 32;
    localparam int LW = $clog2(NL);

    typedef struct {
        logic [DW-1:0] data;
        logic [LW-1:0] lane;
        logic          last;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    scalar_lane_xchg_if #(.NUM_LANES(NL), .DATA_WIDTH(DW)) bus ();
    scalar_lane_xchg #(.NUM_LANES(NL), .DATA_WIDTH(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int            total = 0;
    int            bad = 0;
    int            xfers = 0;
    logic          done_exp = 1'b0;
    exp_t          exp_q[$];
    logic [DW-1:0] lane_mem[NL];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic pack_lanes();
        for (int i = 0; i < NL; i++) bus.I_Lane_Data[i*DW +: DW] = lane_mem[i];
    endtask

    // Reference: one word per set bit, ascending, last on the highest set bit.
    task automatic push_gather(input logic [NL-1:0] m);
        int   hi;
        exp_t e;
        hi = -1;
        for (int i = 0; i < NL; i++) if (m[i]) hi = i;
        for (int i = 0; i < NL; i++) begin
            if (m[i]) begin
                e.data = lane_mem[i];
                e.lane = LW'(i);
                e.last = (i == hi);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_gather(input logic [NL-1:0] m, input bit rnd, output int cyc);
        bit seen;
        push_gather(m);
        bus.I_Gather_Mask = m;
        bus.I_Gather_Req  = 1'b1;
        tick();
        bus.I_Gather_Req = 1'b0;
        if (m == '0) done_exp = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            if (rnd) begin
                bus.I_Gather_Ready = 1'($urandom_range(0, 1));
                lane_mem[$urandom_range(0, NL - 1)] = $urandom;
                pack_lanes();
            end
            @(negedge clock);
            cyc++;
            if (bus.O_Gather_Done) seen = 1'b1;
            tick();
        end
        check("gather_completes", 64'(seen), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_swe"}, 64'(bus.O_SWe), 64'd0);
        check({tag, "_sdata"}, 64'(bus.O_Scalar_Data), 64'd0);
        check({tag, "_ack"}, 64'(bus.O_Bcast_Ack), 64'd0);
        check({tag, "_valid"}, 64'(bus.O_Gather_Valid), 64'd0);
        check({tag, "_gdata"}, 64'(bus.O_Gather_Data), 64'd0);
        check({tag, "_glane"}, 64'(bus.O_Gather_Lane), 64'd0);
        check({tag, "_last"}, 64'(bus.O_Gather_Last), 64'd0);
        check({tag, "_done"}, 64'(bus.O_Gather_Done), 64'd0);
        check({tag, "_busy"}, 64'(bus.O_Busy), 64'd0);
    endtask

    // Monitor: checks Done every cycle and every word that transfers at the coming edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                check("done_pulse", 64'(bus.O_Gather_Done), 64'(done_exp));
                done_exp = 1'b0;
                if (bus.O_Gather_Valid && bus.I_Gather_Ready && !bus.I_Stall) begin
                    xfers++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_word got lane=%0d data=%0h want=no word",
                                 bus.O_Gather_Lane, bus.O_Gather_Data);
                    end else begin
                        e = exp_q.pop_front();
                        check("gather_data", 64'(bus.O_Gather_Data), 64'(e.data));
                        check("gather_lane", 64'(bus.O_Gather_Lane), 64'(e.lane));
                        check("gather_last", 64'(bus.O_Gather_Last), 64'(e.last));
                        if (e.last) done_exp = 1'b1;
                        // The next lane is captured at the same edge this word leaves.
                        if (exp_q.size() != 0) exp_q[0].data = lane_mem[exp_q[0].lane];
                    end
                end
            end
        end
    end

    initial begin
        int            cyc;
        int            x0;
        logic [NL-1:0] m;
        logic [DW-1:0] d;

        bus.I_Stall = 1'b0;
        bus.I_Bcast_Req = 1'b0;
        bus.I_Bcast_Data = '0;
        bus.I_Bcast_Mask = '0;
        bus.I_Gather_Req = 1'b0;
        bus.I_Gather_Mask = '0;
        bus.I_Gather_Ready = 1'b0;
        for (int i = 0; i < NL; i++) lane_mem[i] = '0;
        pack_lanes();

        // Reset held with random inputs
        for (int k = 0; k < 3; k++) begin
            tick();
            bus.I_Stall = 1'($urandom_range(0, 1));
            bus.I_Bcast_Req = 1'($urandom_range(0, 1));
            bus.I_Bcast_Data = $urandom;
            bus.I_Bcast_Mask = NL'($urandom);
            bus.I_Gather_Req = 1'($urandom_range(0, 1));
            bus.I_Gather_Mask = NL'($urandom);
            bus.I_Gather_Ready = 1'($urandom_range(0, 1));
            for (int i = 0; i < NL; i++) lane_mem[i] = $urandom;
            pack_lanes();
            @(negedge clock);
            check_all_zero("in_reset");
        end
        tick();
        bus.I_Stall = 1'b0;
        bus.I_Bcast_Req = 1'b0;
        bus.I_Gather_Req = 1'b0;
        bus.I_Gather_Ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("after_reset");
        tick();

        // Plain broadcast
        bus.I_Bcast_Req = 1'b1;
        bus.I_Bcast_Data = 32'hDEADBEEF;
        bus.I_Bcast_Mask = 16'h0005;
        tick();
        bus.I_Bcast_Req = 1'b0;
        @(negedge clock);
        check("bc_swe", 64'(bus.O_SWe), 64'h0005);
        check("bc_data", 64'(bus.O_Scalar_Data), 64'hDEADBEEF);
        check("bc_ack", 64'(bus.O_Bcast_Ack), 64'd1);
        tick();
        @(negedge clock);
        check("bc_swe_after", 64'(bus.O_SWe), 64'd0);
        check("bc_ack_after", 64'(bus.O_Bcast_Ack), 64'd0);
        check("bc_busy_after", 64'(bus.O_Busy), 64'd0);
        check("bc_data_kept", 64'(bus.O_Scalar_Data), 64'hDEADBEEF);
        tick();

        // Broadcast stalled for three cycles after acceptance
        bus.I_Bcast_Req = 1'b1;
        bus.I_Bcast_Data = 32'hCAFEF00D;
        bus.I_Bcast_Mask = 16'h0005;
        tick();
        bus.I_Bcast_Req = 1'b0;
        bus.I_Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("bcst_swe", 64'(bus.O_SWe), 64'd0);
            check("bcst_ack", 64'(bus.O_Bcast_Ack), 64'd0);
            tick();
        end
        bus.I_Stall = 1'b0;
        @(negedge clock);
        check("bcst_swe_rel", 64'(bus.O_SWe), 64'h0005);
        check("bcst_ack_rel", 64'(bus.O_Bcast_Ack), 64'd1);
        check("bcst_data_rel", 64'(bus.O_Scalar_Data), 64'hCAFEF00D);
        tick();
        @(negedge clock);
        check("bcst_ack_end", 64'(bus.O_Bcast_Ack), 64'd0);
        tick();

        // Gather with ready held high: n lanes -> Done n+1 cycles after the request edge
        for (int i = 0; i < NL; i++) lane_mem[i] = 32'h100 + 32'(i);
        pack_lanes();
        bus.I_Gather_Ready = 1'b1;
        run_gather(16'h8012, 1'b0, cyc);
        check("gather_latency", 64'(cyc), 64'd4);

        // Backpressure with a lane change before and after lane 1 is loaded
        lane_mem[0] = 32'h0A0A0000;
        lane_mem[1] = 32'h0B0B0001;
        pack_lanes();
        bus.I_Gather_Ready = 1'b0;
        x0 = xfers;
        push_gather(16'h0003);
        bus.I_Gather_Mask = 16'h0003;
        bus.I_Gather_Req = 1'b1;
        tick();
        bus.I_Gather_Req = 1'b0;
        lane_mem[1] = 32'hAAAA0001;
        pack_lanes();
        @(negedge clock);
        check("bp_lane0", 64'(bus.O_Gather_Lane), 64'd0);
        check("bp_data0", 64'(bus.O_Gather_Data), 64'h0A0A0000);
        tick();
        bus.I_Gather_Ready = 1'b1;
        @(negedge clock);
        check("bp_hold_valid", 64'(bus.O_Gather_Valid), 64'd1);
        check("bp_hold_data", 64'(bus.O_Gather_Data), 64'h0A0A0000);
        tick();
        bus.I_Gather_Ready = 1'b0;
        lane_mem[1] = 32'hBBBB0002;
        pack_lanes();
        @(negedge clock);
        check("bp_lane1", 64'(bus.O_Gather_Lane), 64'd1);
        check("bp_data1", 64'(bus.O_Gather_Data), 64'hAAAA0001);
        tick();
        bus.I_Gather_Ready = 1'b1;
        @(negedge clock);
        check("bp_data1_held", 64'(bus.O_Gather_Data), 64'hAAAA0001);
        tick();
        @(negedge clock);
        check("bp_valid_end", 64'(bus.O_Gather_Valid), 64'd0);
        check("bp_xfers", 64'(xfers - x0), 64'd2);
        tick();

        // Simultaneous requests: broadcast wins, gather dropped
        bus.I_Bcast_Req = 1'b1;
        bus.I_Bcast_Data = 32'h5A5A5A5A;
        bus.I_Bcast_Mask = 16'h00F0;
        bus.I_Gather_Req = 1'b1;
        bus.I_Gather_Mask = 16'h0003;
        tick();
        bus.I_Bcast_Req = 1'b0;
        bus.I_Gather_Req = 1'b0;
        @(negedge clock);
        check("both_ack", 64'(bus.O_Bcast_Ack), 64'd1);
        check("both_swe", 64'(bus.O_SWe), 64'h00F0);
        check("both_valid", 64'(bus.O_Gather_Valid), 64'd0);
        tick();
        @(negedge clock);
        check("both_valid2", 64'(bus.O_Gather_Valid), 64'd0);
        check("both_busy2", 64'(bus.O_Busy), 64'd0);
        tick();

        // Empty gather mask: Done only
        run_gather(16'h0000, 1'b0, cyc);
        check("empty_latency", 64'(cyc), 64'd1);

        // Reset with two lanes still pending
        bus.I_Gather_Ready = 1'b0;
        push_gather(16'h0007);
        bus.I_Gather_Mask = 16'h0007;
        bus.I_Gather_Req = 1'b1;
        tick();
        bus.I_Gather_Req = 1'b0;
        @(negedge clock);
        check("rst_mid_valid_before", 64'(bus.O_Gather_Valid), 64'd1);
        #1 reset = 1'b0;
        #1;
        check("rst_mid_valid", 64'(bus.O_Gather_Valid), 64'd0);
        check("rst_mid_busy", 64'(bus.O_Busy), 64'd0);
        exp_q.delete();
        done_exp = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            check("rst_mid_done", 64'(bus.O_Gather_Done), 64'd0);
        end
        tick();
        reset = 1'b1;
        bus.I_Gather_Ready = 1'b1;
        repeat (2) tick();

        // Randomized mix of broadcasts and gathers with random ready and lane churn
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                d = $urandom;
                m = NL'($urandom);
                bus.I_Bcast_Req = 1'b1;
                bus.I_Bcast_Data = d;
                bus.I_Bcast_Mask = m;
                tick();
                bus.I_Bcast_Req = 1'b0;
                @(negedge clock);
                check("rnd_bc_swe", 64'(bus.O_SWe), 64'(m));
                check("rnd_bc_data", 64'(bus.O_Scalar_Data), 64'(d));
                check("rnd_bc_ack", 64'(bus.O_Bcast_Ack), 64'd1);
                tick();
            end else begin
                for (int i = 0; i < NL; i++) lane_mem[i] = $urandom;
                pack_lanes();
                m = ($urandom_range(0, 7) == 0) ? '0 : NL'($urandom);
                run_gather(m, 1'b1, cyc);
            end
        end

        repeat (2) tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scalar_lane_xchg.md
Name: scalar_lane_xchg

Overview:
Scalar-unit-side endpoint of the lane scalar-data exchange. It broadcasts one scalar word into the per-lane scalar read registers through a per-lane write enable plus a shared data bus. It also gathers the per-lane scalar write registers, one masked lane at a time, over a valid/ready stream into the scalar unit. It sits between the scalar pipeline and the NUM_LANES TPU lanes.

Parameters:
NUM_LANES, 16, number of lanes served; must be 2 or more.
DATA_WIDTH, 32, scalar word width; equals data_t width.
LANE_W, $clog2(NUM_LANES), width of the lane index.

Ports:
clock  in  1  single clock; all state on posedge.
reset  in  1  asynchronous, active-low (reset==0 resets).
I_Stall  in  1  freezes all state; outputs hold, except O_SWe, which is forced to 0.
I_Bcast_Req  in  1  broadcast request; sampled only in IDLE.
I_Bcast_Data  in  DATA_WIDTH  broadcast word.
I_Bcast_Mask  in  NUM_LANES  target lanes.
O_Bcast_Ack  out  1  one-cycle pulse on the cycle the lane write occurs.
O_SWe  out  NUM_LANES  per-lane scalar write enable to the lanes.
O_Scalar_Data  out  DATA_WIDTH  shared data to lane scalar read registers.
I_Gather_Req  in  1  gather request; sampled only in IDLE.
I_Gather_Mask  in  NUM_LANES  lanes to collect.
I_Lane_Data  in  NUM_LANES*DATA_WIDTH  lane scalar write registers; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
O_Gather_Valid  out  1  output word valid.
O_Gather_Data  out  DATA_WIDTH  gathered word.
O_Gather_Lane  out  LANE_W  source lane index.
O_Gather_Last  out  1  O_Gather_Valid & (no lanes pending).
I_Gather_Ready  in  1  consumer ready.
O_Gather_Done  out  1  one-cycle pulse when a gather completes.
O_Busy  out  1  state != IDLE.

Behaviour:
- Reset (async, reset==0): state = IDLE; every output register and internal register goes to 0; all outputs read 0.
- FSM states: IDLE, BCAST, GATHER. When I_Stall=1, no register changes.
- Requests while O_Busy=1 are ignored (dropped). The requester must check O_Busy.
- If I_Bcast_Req and I_Gather_Req arrive together in IDLE, the broadcast wins and the gather request is dropped.
- Broadcast, request at edge t in IDLE:
  - Latch data and mask; go to BCAST.
  - In cycle t+1 (not stalled): O_SWe = latched mask, O_Scalar_Data = latched data, O_Bcast_Ack = 1. Next state is IDLE.
  - If stalled in BCAST: O_SWe = 0, O_Bcast_Ack = 0, O_Scalar_Data holds, state stays BCAST.
  - Mask of 0: Ack still pulses at t+1 with O_SWe = 0.
  - O_Scalar_Data keeps its last broadcast value after the broadcast; it is not cleared.
- Gather, request at edge t in IDLE with mask M != 0:
  - Let k = lowest set bit of M.
  - At the edge: Out_Data <= lane k data (value captured at that edge), Out_Lane <= k, Valid <= 1, Pend <= M with bit k cleared, state <= GATHER.
- Gather, mask M == 0: stay IDLE, O_Gather_Done = 1 in cycle t+1, O_Gather_Valid stays 0.
- In GATHER, a transfer occurs when O_Gather_Valid & I_Gather_Ready & ~I_Stall. On a transfer:
  - If Pend != 0: load the next lowest pending lane the same way (no bubble; one word per cycle sustained).
  - Else: Valid <= 0, O_Gather_Done <= 1 for one cycle, state <= IDLE.
- Without a transfer, Data, Lane and Valid hold stable; a valid word is never withdrawn.
- Lane data is sampled only when a lane's word is loaded; later changes on I_Lane_Data do not affect a held word.
- Lanes are emitted in ascending index order. Exactly popcount(M) words are emitted, each lane once.
- Done follows the last transfer by one cycle. A new request can be accepted in the cycle Done is high (state is IDLE).
- Reset asserted mid-operation aborts immediately: no Ack, no Done, Valid drops to 0.
- Latency:
  - Broadcast: request to O_SWe is 1 cycle.
  - Gather: request to first O_Gather_Valid is 1 cycle; a full gather of n lanes with ready held at 1 takes n+1 cycles to Done.

Test Plan:
- Reset: hold reset=0 with random inputs. All outputs read 0 and O_Busy=0. Release reset; the block is idle with all outputs still 0.
- Broadcast: Req, data 0xDEADBEEF, mask 0x0005. Next cycle O_SWe=0x0005, O_Scalar_Data=0xDEADBEEF, Ack=1. The following cycle O_SWe=0, O_Busy=0.
- Broadcast under stall: same request, I_Stall=1 for 3 cycles after acceptance. O_SWe=0 and Ack=0 during the stall. Ack and O_SWe=0x0005 appear in the first unstalled cycle.
- Gather, ready=1: lane i data = 0x100+i, mask 0x8012. Words 0x101/lane1, 0x104/lane4, 0x10F/lane15 on consecutive cycles; Last=1 on lane 15; Done on the next cycle.
- Gather backpressure: mask 0x0003, ready toggles 0,1,0,1. Each word holds while ready=0. Exactly two transfers occur, then Done. Changing lane 1's data while lane 0 is waiting changes lane 1's word only if the change happens before lane 1 is loaded.
- Corner cases:
  - Simultaneous Bcast and Gather requests: broadcast only; the gather is dropped.
  - Gather with mask 0: Done at t+1, no Valid.
  - Reset asserted while 2 lanes are pending: Valid=0 immediately, no Done.
